// File: rtl/keypad_entry_ctrl.sv
// Keypad code-entry sequencer: debounced-edge digit capture, code compare, fail lockout.
// Optional inactivity timeout is built when ENTRY_TIMEOUT_EN is defined.
module keypad_entry_ctrl #(
  parameter int DIGITS         = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCK_CYCLES    = 50_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         key_valid,
  input  logic [3:0]                   key_num,
  input  logic                         enter,
  input  logic                         clear,
  input  logic [4*DIGITS-1:0]          code_ref,
  output logic [4*DIGITS-1:0]          entry,
  output logic [$clog2(DIGITS+1)-1:0]  count,
  output logic                         match,
  output logic                         fail,
  output logic                         locked,
  output logic                         timeout,
  output logic [1:0]                   state_dbg
);

  localparam int CW = $clog2(DIGITS+1);
  localparam int FW = $clog2(MAX_FAIL+1);
  localparam int LW = $clog2(LOCK_CYCLES+1);
  localparam logic [CW-1:0] DIGITS_C   = CW'(DIGITS);
  localparam logic [FW-1:0] MAX_FAIL_C = FW'(MAX_FAIL);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_CYCLES-1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ENTRY  = 2'd1,
    S_CHECK  = 2'd2,
    S_LOCKED = 2'd3
  } state_t;

  state_t state, state_d;

  logic kv_q, en_q, cl_q;
  logic key_ev, ent_ev, clr_ev;

  logic [4*DIGITS-1:0] entry_d, entry_shift;
  logic [CW-1:0]       count_d;
  logic                match_d, fail_d, timeout_d;
  logic [FW-1:0]       fail_cnt, fail_cnt_d, fail_cnt_inc;
  logic [LW-1:0]       lock_cnt, lock_cnt_d;

  // Edge registers keep tracking in every state so no stale edge survives lockout.
  assign key_ev = key_valid & ~kv_q;
  assign ent_ev = enter & ~en_q;
  assign clr_ev = clear & ~cl_q;

  assign fail_cnt_inc = fail_cnt + FW'(1);
  assign locked       = (state == S_LOCKED);
  assign state_dbg    = state;

  generate
    if (DIGITS == 1) begin : g_one
      assign entry_shift = key_num;
    end else begin : g_many
      assign entry_shift = {entry[4*DIGITS-5:0], key_num};
    end
  endgenerate

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES-1);
  logic [TW-1:0] idle_cnt, idle_cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else     idle_cnt <= idle_cnt_d;
  end
`endif

  always_comb begin
    state_d    = state;
    entry_d    = entry;
    count_d    = count;
    match_d    = 1'b0;
    fail_d     = 1'b0;
    timeout_d  = 1'b0;
    fail_cnt_d = fail_cnt;
    lock_cnt_d = lock_cnt;
`ifdef ENTRY_TIMEOUT_EN
    idle_cnt_d = idle_cnt;
`endif
    case (state)
      S_IDLE, S_ENTRY: begin
        // clear > enter > digit; a winning event swallows the others that cycle.
        if (clr_ev) begin
          entry_d = '0;
          count_d = '0;
          state_d = S_IDLE;
`ifdef ENTRY_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end else if (ent_ev) begin
          if (state == S_ENTRY) state_d = S_CHECK;
`ifdef ENTRY_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end else if (key_ev && (key_num <= 4'd9) && (count < DIGITS_C)) begin
          entry_d = entry_shift;
          count_d = count + CW'(1);
          state_d = S_ENTRY;
`ifdef ENTRY_TIMEOUT_EN
          idle_cnt_d = '0;
`endif
        end
`ifdef ENTRY_TIMEOUT_EN
        else if (state == S_ENTRY) begin
          if (idle_cnt == TIMEOUT_LAST) begin
            timeout_d  = 1'b1;
            entry_d    = '0;
            count_d    = '0;
            state_d    = S_IDLE;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt + TW'(1);
          end
        end
`endif
      end
      S_CHECK: begin
        entry_d = '0;
        count_d = '0;
        if ((count == DIGITS_C) && (entry == code_ref)) begin
          match_d    = 1'b1;
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          fail_d = 1'b1;
          if (fail_cnt_inc >= MAX_FAIL_C) begin
            fail_cnt_d = '0;
            lock_cnt_d = '0;
            state_d    = S_LOCKED;
          end else begin
            fail_cnt_d = fail_cnt_inc;
            state_d    = S_IDLE;
          end
        end
      end
      S_LOCKED: begin
        if (lock_cnt == LOCK_LAST) begin
          lock_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt + LW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      kv_q     <= 1'b0;
      en_q     <= 1'b0;
      cl_q     <= 1'b0;
      entry    <= '0;
      count    <= '0;
      match    <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      fail_cnt <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_d;
      kv_q     <= key_valid;
      en_q     <= enter;
      cl_q     <= clear;
      entry    <= entry_d;
      count    <= count_d;
      match    <= match_d;
      fail     <= fail_d;
      timeout  <= timeout_d;
      fail_cnt <= fail_cnt_d;
      lock_cnt <= lock_cnt_d;
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: expected match/fail results queued at enter,
// popped when a pulse appears.
module tb_keypad_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int CW     = $clog2(DIGITS+1);
  localparam int LOCKN  = 20;

  logic                clk = 1'b0;
  logic                rst;
  logic                key_valid, enter, clear;
  logic [3:0]          key_num;
  logic [4*DIGITS-1:0] code_ref, entry;
  logic [CW-1:0]       count;
  logic                match, fail, locked, timeout;
  logic [1:0]          state_dbg;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  keypad_entry_ctrl #(
    .DIGITS(DIGITS), .MAX_FAIL(3), .LOCK_CYCLES(LOCKN), .TIMEOUT_CYCLES(30)
  ) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_num(key_num),
    .enter(enter), .clear(clear), .code_ref(code_ref), .entry(entry),
    .count(count), .match(match), .fail(fail), .locked(locked),
    .timeout(timeout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    key_num   = d;
    key_valid = 1'b1;
    repeat (hold) @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic type_code(input logic [15:0] c, input int n);
    for (int i = n - 1; i >= 0; i--) press(c[4*i +: 4], $urandom_range(1, 5));
  endtask

  // exp: 2'b10 = match expected, 2'b01 = fail expected
  task automatic do_enter(input logic [1:0] exp);
    exp_q.push_back(exp);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
  endtask

  task automatic wait_result(input string tag, input logic exp_locked);
    int lat;
    logic [1:0] e;
    lat = 0;
    while (!(match || fail) && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    e = exp_q.pop_front();
    check({tag, "_pulse"}, {30'd0, match, fail}, {30'd0, e});
    check({tag, "_latency"}, lat, 1);
    check({tag, "_count0"}, count, 0);
    check({tag, "_locked"}, locked, exp_locked);
    @(negedge clk);
    check({tag, "_one_cycle"}, {30'd0, match, fail}, 0);
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1; key_valid = 0; key_num = 0; enter = 0; clear = 0; code_ref = 16'h1234;
    repeat (2) @(negedge clk);
    check("rst_entry", entry, 0);
    check("rst_flags", {match, fail, locked, timeout}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", state_dbg, 0);
    check("rst_count", count, 0);

    // Correct code.
    for (int i = 1; i <= 4; i++) press(4'(i), 5);
    check("s1_entry", entry, 16'h1234);
    check("s1_count", count, 4);
    do_enter(2'b10);
    wait_result("s1", 1'b0);

    // Fifth digit ignored, wrong code.
    type_code(16'h1235, 4);
    press(4'd6, 2);
    check("s2_entry", entry, 16'h1235);
    check("s2_count", count, 4);
    do_enter(2'b01);
    wait_result("s2", 1'b0);

    // Correct code zeroes the fail counter; code_ref changes outside CHECK are fine.
    code_ref = 16'h0000;
    type_code(16'h4321, 4);
    code_ref = 16'h4321;
    do_enter(2'b10);
    wait_result("s2b", 1'b0);

    // Three wrong entries, one of them short -> lockout on the third.
    type_code(16'h9999, 4);
    do_enter(2'b01);
    wait_result("s3a", 1'b0);
    type_code(16'h0043, 2);
    do_enter(2'b01);
    wait_result("s3b", 1'b0);
    type_code(16'h4320, 4);
    exp_q.push_back(2'b01);
    enter = 1'b1;
    @(negedge clk);
    enter = 1'b0;
    @(negedge clk);
    check("s3c_pulse", {30'd0, match, fail}, {30'd0, exp_q.pop_front()});
    check("s3c_locked", locked, 1);
    n = 0;
    key_num = 4'd5;
    while (locked && n < 100) begin
      n++;
      key_valid = n[1];
      clear     = n[2];
      enter     = n[3];
      @(negedge clk);
    end
    check("s3_lock_len", n, LOCKN);
    key_valid = 0; clear = 0; enter = 0;
    repeat (2) @(negedge clk);
    check("s3_post_count", count, 0);
    check("s3_post_quiet", {match, fail}, 0);
    type_code(16'h4321, 4);
    do_enter(2'b10);
    wait_result("s3d", 1'b0);

    // Long hold, out-of-range digit, enter in IDLE, clear vs enter.
    press(4'd7, 50);
    check("s4_hold_count", count, 1);
    check("s4_hold_entry", entry, 16'h0007);
    press(4'd12, 3);
    check("s4_bad_digit", count, 1);
    clear = 1; enter = 1;
    @(negedge clk);
    clear = 0; enter = 0;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (match || fail) seen = 1'b1;
    end
    check("s4_clear_wins_pulse", seen, 0);
    check("s4_clear_wins_count", count, 0);
    enter = 1;
    @(negedge clk);
    enter = 0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (match || fail) seen = 1'b1;
    end
    check("s4_idle_enter", seen, 0);

    // Reset mid-lockout and mid-entry.
    for (int k = 0; k < 3; k++) begin
      type_code(16'h0001, 1);
      do_enter(2'b01);
      wait_result("s5_fail", k == 2);
    end
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    check("s5_lock_rst", {match, fail, locked, timeout}, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("s5_lock_state", state_dbg, 0);
    type_code(16'h0056, 2);
    check("s5_two_count", count, 2);
    rst = 1;
    #1;
    check("s5_entry_rst", {16'd0, entry}, 0);
    check("s5_entry_rst_count", count, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("s5_entry_state", state_dbg, 0);

    // Inactivity.
    type_code(16'h0089, 2);
`ifdef ENTRY_TIMEOUT_EN
    n = 0;
    while (!timeout && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("s6_timeout_pulse", timeout, 1);
    check("s6_timeout_count", count, 0);
    @(negedge clk);
    check("s6_timeout_one_cycle", timeout, 0);
`else
    repeat (40) @(negedge clk);
    check("s6_persist_count", count, 2);
    check("s6_persist_entry", entry, 16'h0089);
    check("s6_no_timeout", timeout, 0);
`endif
    check("s6_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
